bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Parametrised, loadable countdown timer built from a chain of BCD digits with a per-digit radix (10 or 6).
//  Generalises the fixed 3-digit coin timer: N digits, any preset, internal tick prescaler, start/pause control
//  and an expiry pulse. Sits between the coin/credit logic (Load/Start) and the seven-segment display drivers.
// PARAMETERS
//  NUM_DIGITS   6          number of BCD digits; digit 0 is least significant
//  RADIX6_MASK  6'b001010  bit i=1 -> digit i counts 5..0 (tens of sec/min); bit i=0 -> digit i counts 9..0
//  TICK_DIV     50000000   Clk cycles per count decrement (>=1; 1 = decrement every enabled cycle)
// PORTS
//  Clk      in   1              system clock, rising edge
//  Reset    in   1              asynchronous, active-high reset
//  Load     in   1              load Preset into count; stops the timer
//  Preset   in   4*NUM_DIGITS   BCD preset, digit i at [4i+3:4i]
//  Start    in   1              begin/resume counting (pulse or level)
//  Pause    in   1              level; holds count and prescaler while high
//  Count    out  4*NUM_DIGITS   current BCD value, digit i at [4i+3:4i]
//  Running  out  1              high while counting is armed
//  Zero     out  1              high when all digits are 0 (combinational from Count)
//  Expired  out  1              one-cycle pulse when the count reaches 0 by decrement
// BEHAVIOUR
//  - Reset (async): Count=0, Running=0, Expired=0, prescaler=0. Zero therefore reads 1.
//  - Per-cycle priority: Load > Start > tick decrement.
//  - Load: Count <= Preset next edge; digits above their max (9, or 5 for radix-6) clamp to max;
//    Running<=0; prescaler<=0; Expired<=0. Start in the same cycle is ignored.
//  - Start: if the loaded Count != 0 -> Running<=1, prescaler<=0. If Count==0 -> ignored, Running stays 0.
//    Start while already Running: no effect (prescaler not restarted).
//  - Prescaler: counts 0..TICK_DIV-1 while Running && !Pause; tick asserted on the cycle it equals
//    TICK_DIV-1, then wraps to 0. Pause freezes the prescaler value (no restart on resume).
//  - Decrement on tick: digit 0 decrements; a digit at 0 wraps to its max (9 or 5) and borrows into
//    digit i+1; the borrow ripples combinationally in the same cycle (Count is updated on a single edge).
//  - Expiry: if the decrement makes Count==0 -> Running<=0 and Expired=1 for exactly that one cycle
//    (registered, same edge as Count becomes 0). The count never wraps from 0 to all-max.
//  - Latency: first decrement occurs TICK_DIV cycles after the edge that sets Running.
//  - Pause && tick cannot both act: Pause blocks the tick and the prescaler.
//  - Reset mid-count: immediate clear, no Expired pulse.
//  - Load while Running or Paused: aborts the run, Running=0, no Expired pulse.
// STRUCTURE
//  - Shared package timer_pkg: BCD_W=4, DIGIT_MAX_10=4'd9, DIGIT_MAX_6=4'd5,
//    function digit_max(radix6), and clamp helper used by the coin and display blocks.
//  - Sub-module bcd_down_digit (one per digit, generate loop): inputs Clk, Reset, load, load_val,
//    dec, radix6; outputs q[3:0], borrow_out = dec && (q==0). Top holds the prescaler, Running FSM
//    (IDLE/RUN/PAUSED, with PAUSED = Running && Pause) and the Expired register.
// TESTING  (bench uses NUM_DIGITS=3, RADIX6_MASK=3'b010, TICK_DIV=4)
//  1 Reset asserted mid-run with Count=1:23 -> Count=000, Running=0, Zero=1, Expired never pulses.
//  2 Load Preset=0x159, Start -> Count 0x158 after 4 cycles; after 9 ticks 0x150, next tick 0x149.
//  3 Load 0x100, Start -> after 1 tick Count=0x059 (radix-6 wrap of digit 1, borrow into digit 2).
//  4 Load 0x002, Start -> 0x001 then 0x000 with Expired=1 for one cycle, Running=0; further ticks hold 0x000.
//  5 Running at 0x030 prescaler=2, Pause high 10 cycles -> Count and prescaler frozen; release ->
//    decrement exactly 2 cycles later to 0x029.
//  6 Load 0x0FA (invalid) -> Count=0x059 clamped; Start with Load 0x000 -> Running stays 0, no Expired;
//    Load and Start same cycle -> Count=Preset, Running=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared BCD timer definitions: digit width, per-radix digit limits and helpers
// used by the countdown timer, coin logic and display blocks.
package timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX_10 = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MAX_6  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } run_state_t;

    function automatic logic [BCD_W-1:0] digit_max(input logic radix6);
        return radix6 ? DIGIT_MAX_6 : DIGIT_MAX_10;
    endfunction

    // Out-of-range BCD codes (A..F, or 6..9 on a radix-6 digit) saturate to the digit max.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d, input logic radix6);
        logic [BCD_W-1:0] lim;
        lim = digit_max(radix6);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with selectable radix (10 or 6) and a
// combinational borrow that feeds the next more significant digit.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    input  logic             radix6,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(load_val, radix6);
        end else if (dec) begin
            q <= (q == '0) ? digit_max(radix6) : q - 4'd1;
        end
    end

    assign borrow_out = dec && (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable N-digit BCD countdown timer with tick prescaler, start/pause control
// and a single-cycle expiry pulse.
//
//  state     | meaning
//  ST_IDLE   | not counting; waits for Start with a nonzero count
//  ST_RUN    | armed, prescaler advancing, ticks decrement the count
//  ST_PAUSED | armed but Pause is high; count and prescaler frozen
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int                    NUM_DIGITS  = 6,
    parameter logic [NUM_DIGITS-1:0] RADIX6_MASK = 6'b001010,
    parameter int                    TICK_DIV    = 50000000
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Load,
    input  logic [BCD_W*NUM_DIGITS-1:0] Preset,
    input  logic                        Start,
    input  logic                        Pause,
    output logic [BCD_W*NUM_DIGITS-1:0] Count,
    output logic                        Running,
    output logic                        Zero,
    output logic                        Expired
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [BCD_W*NUM_DIGITS-1:0] COUNT_ONE = {{(BCD_W*NUM_DIGITS-1){1'b0}}, 1'b1};

    run_state_t            runState;
    logic [PRE_W-1:0]      preCnt;
    logic [NUM_DIGITS-1:0] digitDec;
    logic [NUM_DIGITS-1:0] digitBorrow;
    logic                  tickNow;
    logic                  expiring;
    logic                  underflow;

    assign tickNow  = Running && !Pause && (preCnt == PRE_LAST);
    // Only a count of exactly one can reach zero on a decrement.
    assign expiring = tickNow && !Load && (Count == COUNT_ONE);
    // Borrow out of the top digit cannot happen while the count is guarded nonzero;
    // if it ever did, stopping the run is the safe reaction.
    assign underflow = digitBorrow[NUM_DIGITS-1];
    assign Zero      = (Count == '0);

    assign digitDec[0] = tickNow && !Load;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_chain
            assign digitDec[gi] = digitBorrow[gi-1];
        end

        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_down_digit u_digit (
                .Clk        (Clk),
                .Reset      (Reset),
                .load       (Load),
                .load_val   (Preset[BCD_W*gi +: BCD_W]),
                .dec        (digitDec[gi]),
                .radix6     (RADIX6_MASK[gi]),
                .q          (Count[BCD_W*gi +: BCD_W]),
                .borrow_out (digitBorrow[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            runState <= ST_IDLE;
            Running  <= 1'b0;
            Expired  <= 1'b0;
            preCnt   <= '0;
        end else begin
            Expired <= 1'b0;
            if (Load) begin
                runState <= ST_IDLE;
                Running  <= 1'b0;
                preCnt   <= '0;
            end else begin
                case (runState)
                    ST_IDLE: begin
                        if (Start && !Zero) begin
                            runState <= Pause ? ST_PAUSED : ST_RUN;
                            Running  <= 1'b1;
                            preCnt   <= '0;
                        end
                    end
                    ST_RUN, ST_PAUSED: begin
                        if (expiring || underflow) begin
                            runState <= ST_IDLE;
                            Running  <= 1'b0;
                            preCnt   <= '0;
                            Expired  <= expiring;
                        end else begin
                            runState <= Pause ? ST_PAUSED : ST_RUN;
                            if (!Pause) begin
                                preCnt <= tickNow ? '0 : preCnt + PRE_W'(1);
                            end
                        end
                    end
                    default: begin
                        runState <= ST_IDLE;
                        Running  <= 1'b0;
                        preCnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: per-cycle comparison against an integer-valued model of the
// mixed-radix count, directed scenarios with literal expectations, then random traffic.
module tb_bcd_countdown_timer;

    localparam int ND = 3;
    localparam int TD = 4;

    logic        Clk = 1'b0;
    logic        Reset, Load, Start, Pause;
    logic [11:0] Preset;
    logic [11:0] Count;
    logic        Running, Zero, Expired;

    int nChecks = 0;
    int nPass   = 0;

    int mVal = 0;
    int mPre = 0;
    bit mRun = 1'b0;
    bit mExp = 1'b0;

    bcd_countdown_timer #(.NUM_DIGITS(ND), .RADIX6_MASK(3'b010), .TICK_DIV(TD)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load    (Load),
        .Preset  (Preset),
        .Start   (Start),
        .Pause   (Pause),
        .Count   (Count),
        .Running (Running),
        .Zero    (Zero),
        .Expired (Expired)
    );

    always #5 Clk = ~Clk;

    function automatic int dmax(input int i);
        logic [2:0] m;
        m = 3'b010;
        return m[i] ? 5 : 9;
    endfunction

    // Mixed-radix BCD -> integer, saturating invalid digits.
    function automatic int toInt(input logic [11:0] b);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < ND; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > dmax(i)) d = dmax(i);
            v += d * w;
            w *= dmax(i) + 1;
        end
        return v;
    endfunction

    function automatic logic [11:0] toBcd(input int v);
        logic [11:0] b;
        int r;
        b = '0;
        for (int i = 0; i < ND; i++) begin
            r = dmax(i) + 1;
            b[4*i +: 4] = 4'(v % r);
            v = v / r;
        end
        return b;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            mVal = 0; mRun = 0; mPre = 0; mExp = 0;
        end else begin
            mExp = 0;
            if (Load) begin
                mVal = toInt(Preset); mRun = 0; mPre = 0;
            end else if (Start && !mRun) begin
                if (mVal != 0) begin
                    mRun = 1; mPre = 0;
                end
            end else if (mRun && !Pause) begin
                if (mPre == TD - 1) begin
                    mPre = 0;
                    mVal = mVal - 1;
                    if (mVal == 0) begin
                        mRun = 0; mExp = 1;
                    end
                end else begin
                    mPre = mPre + 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        logic [11:0] expCount;
        expCount = toBcd(mVal);
        nChecks++;
        if ({Count, Running, Zero, Expired} === {expCount, mRun, (mVal == 0), mExp})
            nPass++;
        else
            $display("FAIL model_cmp t=%0t: got Count=%03h Running=%0b Zero=%0b Expired=%0b, want Count=%03h Running=%0b Zero=%0b Expired=%0b",
                     $time, Count, Running, Zero, Expired, expCount, mRun, (mVal == 0), mExp);
    end

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step(input logic l, input logic [11:0] p, input logic s, input logic pa);
        Load = l; Preset = p; Start = s; Pause = pa;
        @(negedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, Preset, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; Start = 1'b0; Pause = 1'b0; Preset = '0;
        @(negedge Clk); #1;
        checkLit("reset_count", 32'(Count), 32'h000);
        checkLit("reset_running", 32'(Running), 32'h0);
        checkLit("reset_zero", 32'(Zero), 32'h1);
        Reset = 1'b0;
        idle(2);

        // Reset mid-run at 1:23
        step(1'b1, 12'h123, 1'b0, 1'b0);
        step(1'b0, 12'h123, 1'b1, 1'b0);
        idle(6);
        checkLit("s1_pre_reset", 32'(Count), 32'h122);
        Reset = 1'b1;
        #1;
        checkLit("s1_count", 32'(Count), 32'h000);
        checkLit("s1_running", 32'(Running), 32'h0);
        checkLit("s1_zero", 32'(Zero), 32'h1);
        idle(2);
        Reset = 1'b0;
        idle(6);
        checkLit("s1_no_expire", 32'(Expired), 32'h0);

        // 0x159: latency and ripple
        step(1'b1, 12'h159, 1'b0, 1'b0);
        step(1'b0, 12'h159, 1'b1, 1'b0);
        checkLit("s2_running", 32'(Running), 32'h1);
        idle(3);
        checkLit("s2_before_tick", 32'(Count), 32'h159);
        idle(1);
        checkLit("s2_first_tick", 32'(Count), 32'h158);
        idle(32);
        checkLit("s2_nine_ticks", 32'(Count), 32'h150);
        idle(4);
        checkLit("s2_borrow", 32'(Count), 32'h149);

        // 0x100: radix-6 wrap with borrow into the top digit
        step(1'b1, 12'h100, 1'b0, 1'b0);
        step(1'b0, 12'h100, 1'b1, 1'b0);
        idle(4);
        checkLit("s3_wrap", 32'(Count), 32'h059);

        // 0x002: expiry
        step(1'b1, 12'h002, 1'b0, 1'b0);
        step(1'b0, 12'h002, 1'b1, 1'b0);
        idle(4);
        checkLit("s4_one", 32'(Count), 32'h001);
        idle(3);
        checkLit("s4_pre_expire", 32'(Expired), 32'h0);
        idle(1);
        checkLit("s4_zero", 32'(Count), 32'h000);
        checkLit("s4_expired", 32'(Expired), 32'h1);
        checkLit("s4_stopped", 32'(Running), 32'h0);
        idle(1);
        checkLit("s4_pulse_end", 32'(Expired), 32'h0);
        idle(8);
        checkLit("s4_hold", 32'(Count), 32'h000);

        // Pause with prescaler at 2
        step(1'b1, 12'h031, 1'b0, 1'b0);
        step(1'b0, 12'h031, 1'b1, 1'b0);
        idle(4);
        checkLit("s5_030", 32'(Count), 32'h030);
        idle(2);
        repeat (10) step(1'b0, Preset, 1'b0, 1'b1);
        checkLit("s5_frozen", 32'(Count), 32'h030);
        checkLit("s5_still_running", 32'(Running), 32'h1);
        idle(1);
        checkLit("s5_release1", 32'(Count), 32'h030);
        idle(1);
        checkLit("s5_release2", 32'(Count), 32'h029);

        // Clamp, start at zero, load+start together
        step(1'b1, 12'h0FA, 1'b0, 1'b0);
        checkLit("s6_clamp", 32'(Count), 32'h059);
        step(1'b1, 12'h000, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        idle(1);
        checkLit("s6_zero_start", 32'(Running), 32'h0);
        checkLit("s6_zero_noexp", 32'(Expired), 32'h0);
        step(1'b1, 12'h045, 1'b1, 1'b0);
        checkLit("s6_ld_st_count", 32'(Count), 32'h045);
        checkLit("s6_ld_st_run", 32'(Running), 32'h0);
        idle(2);

        // Random traffic, biased toward small presets so expiries occur
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] p;
            Reset = ($urandom_range(0, 299) == 0);
            p = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
            step($urandom_range(0, 15) == 0, p, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        Reset = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
